cla_16_bit_ripple: RTL and testbench



---
 rtl/cla_16_bit_ripple_pkg.sv | 7 +
 rtl/cla_16_bit_ripple_cla4.sv | 40 ++++
 rtl/cla_16_bit_ripple.sv | 45 ++++
 tb/tb_cla_16_bit_ripple.sv | 118 +++++++++++
 4 files changed

// File: rtl/cla_16_bit_ripple_pkg.sv
// Shared widths for the 16-bit ripple-of-CLA-groups adder.
// The adder is built from 4-bit lookahead groups chained by ripple carry.
package cla_16_bit_ripple_pkg;
    localparam int ADDER_WIDTH     = 16;
    localparam int CLA_GROUP_WIDTH = 4;
    localparam int NUM_GROUPS      = ADDER_WIDTH / CLA_GROUP_WIDTH;
endpackage

// File: rtl/cla_16_bit_ripple_cla4.sv
// Combinational 4-bit carry-lookahead group.
// Every internal carry and the group carry-out are flat sum-of-products of g/p/cin.
module cla_4_bit
    import cla_16_bit_ripple_pkg::*;
(
    input  logic [CLA_GROUP_WIDTH-1:0] a,
    input  logic [CLA_GROUP_WIDTH-1:0] b,
    input  logic                       cin,
    output logic [CLA_GROUP_WIDTH-1:0] sum,
    output logic                       cout
);

    logic [CLA_GROUP_WIDTH-1:0] g;
    logic [CLA_GROUP_WIDTH-1:0] p;
    logic [CLA_GROUP_WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Two-level form: no carry is built from the previous internal carry.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[CLA_GROUP_WIDTH-1:0];
    assign cout = c[CLA_GROUP_WIDTH];

endmodule

// File: rtl/cla_16_bit_ripple.sv
// 16-bit registered adder: four CLA groups rippling carry, result captured each clk.
// Synchronous active-low reset clears sum and cout.
module cla_16_bit_ripple
    import cla_16_bit_ripple_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   cin,
    output logic                   cout,
    output logic [ADDER_WIDTH-1:0] sum
);

    logic [NUM_GROUPS-1:0][CLA_GROUP_WIDTH-1:0] grp_a;
    logic [NUM_GROUPS-1:0][CLA_GROUP_WIDTH-1:0] grp_b;
    logic [NUM_GROUPS-1:0][CLA_GROUP_WIDTH-1:0] grp_sum;
    logic [NUM_GROUPS:0]                        carry;

    assign grp_a    = a;
    assign grp_b    = b;
    assign carry[0] = cin;

    // Group i carry-out drives group i+1 carry-in.
    for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_grp
        cla_4_bit u_cla (
            .a    (grp_a[i]),
            .b    (grp_b[i]),
            .cin  (carry[i]),
            .sum  (grp_sum[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= grp_sum;
            cout <= carry[NUM_GROUPS];
        end
    end

endmodule

// File: tb/tb_cla_16_bit_ripple.sv
// Bench for cla_16_bit_ripple: directed table, reset/latency sequences, random vs a+b+cin.
module tb_cla_16_bit_ripple;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin;
    logic        cout;
    logic [15:0] sum;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[9];

    cla_16_bit_ripple dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .cout  (cout),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return r[16:0];
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     name, act[16], act[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Drive inputs, take one edge, sample just after it.
    task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a = va; b = vb; cin = vc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'hFF3F, 16'h5555, 1'b0, 16'h5494, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[8] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};

        // Reset dominates a maximal add for two edges.
        rst_n = 1'b0;
        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("reset_edge1", {cout, sum}, 17'h0_0000);
        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("reset_edge2", {cout, sum}, 17'h0_0000);
        rst_n = 1'b1;
        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("reset_release", {cout, sum}, 17'h1_FFFF);

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("table%0d", i), {cout, sum}, {vecs[i].cout, vecs[i].sum});
        end

        // Outputs hold while inputs change between edges.
        a = 16'h0001; b = 16'h0001; cin = 1'b1;
        #3;
        check("hold_between_edges", {cout, sum}, {vecs[8].cout, vecs[8].sum});
        step(16'h0001, 16'h0001, 1'b1);
        check("after_hold", {cout, sum}, 17'h0_0003);

        // Back-to-back stream with a one-edge reset in the middle.
        step(16'h1111, 16'h2222, 1'b0);
        check("stream0", {cout, sum}, 17'h0_3333);
        rst_n = 1'b0;
        step(16'hF000, 16'h1000, 1'b0);
        check("stream_reset", {cout, sum}, 17'h0_0000);
        rst_n = 1'b1;
        step(16'hF000, 16'h1000, 1'b1);
        check("stream_after_reset", {cout, sum}, 17'h1_0001);
        step(16'hABCD, 16'h0000, 1'b0);
        check("stream2", {cout, sum}, 17'h0_ABCD);

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            step(ra, rb, rc);
            check("random", {cout, sum}, ref_add(ra, rb, rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
